// File: rtl/lzc_pipe.sv
// Registered leading/trailing zero counter built on a binary-tree priority encoder.
// Optional macro LZC_PIPE_EXTRA_STAGE_EN splits the tree with a mid-level register (latency 2).
module lzc_pipe #(
    parameter  int WIDTH     = 16,
    parameter  int MODE      = 0,
    localparam int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     in_i,
    output logic                 valid_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    localparam int PW = 1 << CNT_WIDTH;
`ifdef LZC_PIPE_EXTRA_STAGE_EN
    localparam int NS = 1 << (CNT_WIDTH / 2);
`else
    localparam int NS = 1;
`endif

    if (WIDTH < 1 || WIDTH > 256 || (MODE != 0 && MODE != 1)) begin : g_badParam
        $fatal(1, "lzc_pipe: illegal parameters WIDTH=%0d MODE=%0d", WIDTH, MODE);
    end

    logic [PW-1:0]        w_vec;
    logic                 w_nodeAny [NS:2*PW-1];
    logic [CNT_WIDTH-1:0] w_nodeIdx [NS:2*PW-1];

    // Heap-ordered tree: node n has children 2n (lower bit indices) and 2n+1.
    // Leaves sit at PW+i; padding bits above WIDTH stay zero so they never win.
    always_comb begin
        w_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_vec[i] = (MODE == 1) ? in_i[WIDTH-1-i] : in_i[i];
        end
        for (int i = 0; i < PW; i++) begin
            w_nodeAny[PW+i] = w_vec[i];
            w_nodeIdx[PW+i] = CNT_WIDTH'(i);
        end
        for (int n = PW - 1; n >= NS; n--) begin
            w_nodeAny[n] = w_nodeAny[2*n] | w_nodeAny[2*n+1];
            w_nodeIdx[n] = w_nodeAny[2*n] ? w_nodeIdx[2*n] : w_nodeIdx[2*n+1];
        end
    end

    logic                 w_resValid;
    logic                 w_resAny;
    logic [CNT_WIDTH-1:0] w_resIdx;

`ifdef LZC_PIPE_EXTRA_STAGE_EN
    logic                 r_midValid;
    logic                 r_midAny [NS:2*NS-1];
    logic [CNT_WIDTH-1:0] r_midIdx [NS:2*NS-1];
    logic                 w_topAny [1:2*NS-1];
    logic [CNT_WIDTH-1:0] w_topIdx [1:2*NS-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_midValid <= 1'b0;
            for (int n = NS; n < 2*NS; n++) begin
                r_midAny[n] <= 1'b0;
                r_midIdx[n] <= '0;
            end
        end else begin
            r_midValid <= valid_i;
            if (valid_i) begin
                for (int n = NS; n < 2*NS; n++) begin
                    r_midAny[n] <= w_nodeAny[n];
                    r_midIdx[n] <= w_nodeIdx[n];
                end
            end
        end
    end

    // Upper half of the tree, fed from the registered mid-level nodes.
    always_comb begin
        for (int n = NS; n < 2*NS; n++) begin
            w_topAny[n] = r_midAny[n];
            w_topIdx[n] = r_midIdx[n];
        end
        for (int n = NS - 1; n >= 1; n--) begin
            w_topAny[n] = w_topAny[2*n] | w_topAny[2*n+1];
            w_topIdx[n] = w_topAny[2*n] ? w_topIdx[2*n] : w_topIdx[2*n+1];
        end
    end

    assign w_resValid = r_midValid;
    assign w_resAny   = w_topAny[1];
    assign w_resIdx   = w_topIdx[1];
`else
    assign w_resValid = valid_i;
    assign w_resAny   = w_nodeAny[1];
    assign w_resIdx   = w_nodeIdx[1];
`endif

    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_empty;

    // Data only loads on a qualified result so idle inputs never reach the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
        end else begin
            r_valid <= w_resValid;
            if (w_resValid) begin
                r_cnt   <= w_resAny ? w_resIdx : '0;
                r_empty <= ~w_resAny;
            end
        end
    end

    assign valid_o = r_valid;
    assign cnt_o   = r_cnt;
    assign empty_o = r_empty;

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed self-checking bench for lzc_pipe across several WIDTH/MODE instances.
// Latency follows LZC_PIPE_EXTRA_STAGE_EN (1 or 2 cycles).
module tb_lzc_pipe;

`ifdef LZC_PIPE_EXTRA_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [32:0] stim;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic       vT16, eT16, vL16, eL16, vL12, eL12, vT1, eT1, vL1, eL1;
    logic       vT5, eT5, vL5, eL5, vT33, eT33, vL33, eL33;
    logic [3:0] cT16, cL16, cL12;
    logic [0:0] cT1, cL1;
    logic [2:0] cT5, cL5;
    logic [5:0] cT33, cL33;

    lzc_pipe #(.WIDTH(16), .MODE(0)) uT16 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[15:0]),
                                           .valid_o(vT16), .cnt_o(cT16), .empty_o(eT16));
    lzc_pipe #(.WIDTH(16), .MODE(1)) uL16 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[15:0]),
                                           .valid_o(vL16), .cnt_o(cL16), .empty_o(eL16));
    lzc_pipe #(.WIDTH(12), .MODE(1)) uL12 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[11:0]),
                                           .valid_o(vL12), .cnt_o(cL12), .empty_o(eL12));
    lzc_pipe #(.WIDTH(1), .MODE(0)) uT1 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[0:0]),
                                         .valid_o(vT1), .cnt_o(cT1), .empty_o(eT1));
    lzc_pipe #(.WIDTH(1), .MODE(1)) uL1 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[0:0]),
                                         .valid_o(vL1), .cnt_o(cL1), .empty_o(eL1));
    lzc_pipe #(.WIDTH(5), .MODE(0)) uT5 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[4:0]),
                                         .valid_o(vT5), .cnt_o(cT5), .empty_o(eT5));
    lzc_pipe #(.WIDTH(5), .MODE(1)) uL5 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[4:0]),
                                         .valid_o(vL5), .cnt_o(cL5), .empty_o(eL5));
    lzc_pipe #(.WIDTH(33), .MODE(0)) uT33 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[32:0]),
                                           .valid_o(vT33), .cnt_o(cT33), .empty_o(eT33));
    lzc_pipe #(.WIDTH(33), .MODE(1)) uL33 (.clk_i(clk), .rst_i(rst), .valid_i(valid), .in_i(stim[32:0]),
                                           .valid_o(vL33), .cnt_o(cL33), .empty_o(eL33));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One qualified vector, then idle (random data) until its result is visible.
    task automatic applyStimulus(input logic [32:0] v);
        valid = 1'b1;
        stim  = v;
        tick();
        valid = 1'b0;
        stim  = {$urandom, $urandom};
        repeat (LAT - 1) tick();
    endtask

    task automatic refCount(input logic [32:0] v, input int w, input int mode,
                            output int cnt, output bit empty);
        cnt   = 0;
        empty = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (empty && v[(mode == 1) ? (w - 1 - i) : i]) begin
                cnt   = i;
                empty = 1'b0;
            end
        end
    endtask

    task automatic checkUnit(input string tag, input int w, input int mode, input logic [32:0] v,
                             input logic vo, input logic [5:0] co, input logic eo);
        int expCnt;
        bit expEmpty;
        refCount(v, w, mode, expCnt, expEmpty);
        checkOutput({tag, "_valid"}, vo, 1);
        checkOutput({tag, "_cnt"}, co, expCnt);
        checkOutput({tag, "_empty"}, eo, expEmpty);
    endtask

    initial begin
        logic [15:0] streamVec [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0000};
        int          streamCnt [4] = '{0, 1, 2, 0};
        int          streamEmp [4] = '{0, 0, 0, 1};
        logic [32:0] rv;

        rst   = 1'b1;
        valid = 1'b0;
        stim  = '0;
        #2;
        checkOutput("rst_valid", vT16, 0);
        checkOutput("rst_cnt", cT16, 0);
        checkOutput("rst_empty", eT16, 1);
        checkOutput("rst_empty33", eL33, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(33'h0008);
        checkOutput("t16_0008_valid", vT16, 1);
        checkOutput("t16_0008_cnt", cT16, 3);
        checkOutput("t16_0008_empty", eT16, 0);
        checkOutput("l16_0008_cnt", cL16, 12);

        applyStimulus(33'h8000);
        checkOutput("t16_8000_cnt", cT16, 15);
        checkOutput("l16_8000_cnt", cL16, 0);
        tick();
        checkOutput("idle_valid", vT16, 0);
        checkOutput("idle_hold_cnt", cT16, 15);
        checkOutput("idle_hold_empty", eT16, 0);
        tick();
        checkOutput("idle2_hold_cnt", cT16, 15);

        applyStimulus(33'h0100);
        checkOutput("l16_0100_cnt", cL16, 7);
        checkOutput("t16_0100_cnt", cT16, 8);

        applyStimulus(33'hFFFF);
        checkOutput("l16_ffff_cnt", cL16, 0);
        checkOutput("l16_ffff_empty", eL16, 0);
        checkOutput("t16_ffff_cnt", cT16, 0);

        applyStimulus(33'h0000);
        checkOutput("zero_l16_valid", vL16, 1);
        checkOutput("zero_l16_empty", eL16, 1);
        checkOutput("zero_l16_cnt", cL16, 0);
        checkOutput("zero_t16_empty", eT16, 1);
        checkOutput("zero_t1_empty", eT1, 1);
        checkOutput("zero_l33_cnt", cL33, 0);

        applyStimulus(33'h001);
        checkOutput("l12_001_cnt", cL12, 11);
        checkOutput("t1_1_cnt", cT1, 0);
        checkOutput("t1_1_empty", eT1, 0);
        checkOutput("l1_1_empty", eL1, 0);
        checkOutput("l5_1_cnt", cL5, 4);
        checkOutput("t5_1_cnt", cT5, 0);

        applyStimulus(33'h004);
        checkOutput("l5_4_cnt", cL5, 2);
        checkOutput("t5_4_cnt", cT5, 2);

        applyStimulus(33'h1_0000_0000);
        checkOutput("t33_top_cnt", cT33, 32);
        checkOutput("l33_top_cnt", cL33, 0);
        checkOutput("t16_pad_empty", eT16, 1);

        applyStimulus(33'h1_0010_0000);
        checkOutput("t33_b20_cnt", cT33, 20);

        // Back-to-back stream, results LAT cycles behind the inputs.
        for (int k = 0; k < 4 + LAT - 1; k++) begin
            if (k < 4) begin
                valid = 1'b1;
                stim  = {17'h0, streamVec[k]};
            end else begin
                valid = 1'b0;
            end
            tick();
            if (k - (LAT - 1) >= 0) begin
                checkOutput($sformatf("stream%0d_valid", k - (LAT - 1)), vT16, 1);
                checkOutput($sformatf("stream%0d_cnt", k - (LAT - 1)), cT16, streamCnt[k - (LAT - 1)]);
                checkOutput($sformatf("stream%0d_empty", k - (LAT - 1)), eT16, streamEmp[k - (LAT - 1)]);
            end
        end
        valid = 1'b0;
        tick();
        checkOutput("stream_end_valid", vT16, 0);
        checkOutput("stream_end_cnt", cT16, 0);
        checkOutput("stream_end_empty", eT16, 1);

        // Asynchronous reset between edges, with a capture in flight.
        applyStimulus(33'h0008);
        valid = 1'b1;
        stim  = 33'h0001;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", vT16, 0);
        checkOutput("arst_cnt", cT16, 0);
        checkOutput("arst_empty", eT16, 1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tick();
            checkOutput($sformatf("arst_flush%0d_valid", k), vT16, 0);
        end

        // Sparse random sweep against the loop reference model.
        for (int it = 0; it < 24; it++) begin
            rv = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (it % 4 == 0) rv = '0;
            applyStimulus(rv);
            checkUnit($sformatf("rnd%0d_t1", it), 1, 0, rv, vT1, 6'(cT1), eT1);
            checkUnit($sformatf("rnd%0d_l1", it), 1, 1, rv, vL1, 6'(cL1), eL1);
            checkUnit($sformatf("rnd%0d_t5", it), 5, 0, rv, vT5, 6'(cT5), eT5);
            checkUnit($sformatf("rnd%0d_l5", it), 5, 1, rv, vL5, 6'(cL5), eL5);
            checkUnit($sformatf("rnd%0d_t16", it), 16, 0, rv, vT16, 6'(cT16), eT16);
            checkUnit($sformatf("rnd%0d_l16", it), 16, 1, rv, vL16, 6'(cL16), eL16);
            checkUnit($sformatf("rnd%0d_l12", it), 12, 1, rv, vL12, 6'(cL12), eL12);
            checkUnit($sformatf("rnd%0d_t33", it), 33, 0, rv, vT33, cT33, eT33);
            checkUnit($sformatf("rnd%0d_l33", it), 33, 1, rv, vL33, cL33, eL33);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_pipe.md
Name: lzc_pipe

Overview:
Registered leading/trailing zero counter (common-cells family) for datapath normalization and priority-encoding users such as FPU normalizers and arbiters. The block takes a WIDTH-bit vector with a valid strobe. One cycle later it presents the number of zeros counted from the selected end, plus an all-zero flag. It is built as a combinational binary-tree priority encoder followed by an output register stage.

Parameters:
- WIDTH, 16: input vector width; legal range 1..256.
- MODE, 0: 0 = trailing-zero count (from bit 0 upward); 1 = leading-zero count (from bit WIDTH-1 downward).
- CNT_WIDTH, derived: equals clog2(WIDTH) when WIDTH > 1, else 1. Not user-overridable.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  qualifies in_i for capture this cycle.
- in_i  in  WIDTH  vector to scan.
- valid_o  out  1  cnt_o/empty_o hold a fresh result.
- cnt_o  out  CNT_WIDTH  zero count from the selected end.
- empty_o  out  1  high when the captured in_i was all zeros.

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-high (rst_i).
- Reset values, asserted immediately on rst_i high independent of the clock: valid_o=0, cnt_o=0, empty_o=1. State stays there while rst_i is high.
- Count definition:
  - MODE=0: cnt_o = index of the lowest set bit.
  - MODE=1: cnt_o = (WIDTH-1) - index of the highest set bit.
  - Result is unsigned, range 0..WIDTH-1.
- All-zero input: empty_o=1 and cnt_o=0. Consumers must qualify cnt_o with empty_o.
- Latency is 1 cycle. If valid_i=1 at edge N, the result of in_i is visible after edge N, and valid_o=1 for exactly the cycle following edge N.
- valid_i=0 at an edge: valid_o=0 next cycle. cnt_o and empty_o hold their last captured values; there is no toggling on idle cycles.
- Back-to-back valid_i: one result per cycle, no bubbles, no backpressure (no ready signal).
- Combinational core:
  - Reduction tree of depth CNT_WIDTH.
  - Each node combines two children: takes the left-child index if the left child has a set bit, else the right-child index.
  - Leaf "left" is bit 0 for MODE=0 and bit WIDTH-1 for MODE=1 (implemented by bit-reversing in_i for MODE=1).
  - Non-power-of-two WIDTH: pad to the next power of two with zeros on the far end, so padding never affects the result.
- WIDTH=1:
  - CNT_WIDTH=1 and cnt_o is always 0.
  - empty_o = ~in_i[0].
- Reset mid-operation: a capture in flight is discarded. The first valid_o after reset release requires a new valid_i.
- X/unknown in_i while valid_i=0 must not propagate to outputs.
- Elaboration: report a fatal error if WIDTH < 1 or WIDTH > 256, or if MODE is not 0 or 1.

Optional Feature:
Macro LZC_PIPE_EXTRA_STAGE_EN.
- Defined:
  - Adds a second register stage that splits the tree at its midpoint level.
  - Latency becomes 2 cycles; throughput stays 1 result per cycle.
  - valid_o tracks valid_i delayed by 2 edges.
  - Intermediate valid and data registers reset to 0 and 0/empty respectively.
  - Hold-on-idle applies at the output stage.
- Undefined: single output register, latency 1, exactly as described above.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> valid_o=0, cnt_o=0, empty_o=1 immediately, without waiting for a clock edge.
- MODE=0, WIDTH=16, valid_i=1, in_i=0x0008 -> next cycle valid_o=1, cnt_o=3, empty_o=0. Then in_i=0x8000 -> cnt_o=15.
- MODE=1, WIDTH=16, in_i=0x0100 -> cnt_o=7. Then in_i=0xFFFF -> cnt_o=0, empty_o=0.
- All-zero: in_i=0x0000 in either MODE -> empty_o=1, cnt_o=0, valid_o=1.
- Streaming and idle:
  - Stimulus: valid_i=1 for 4 cycles with in_i = 0x0001, 0x0002, 0x0004, 0x0000 (MODE=0), then valid_i=0.
  - Response: cnt_o = 0, 1, 2, 0 on consecutive cycles, with empty_o=1 on the last; valid_o then drops and the last values hold.
- WIDTH=12, MODE=1, in_i=0x001 -> cnt_o=11. Random sweep against a reference model for WIDTH in {1, 5, 16, 33}, both modes, with and without LZC_PIPE_EXTRA_STAGE_EN (latency 2).
